// File: rtl/pcileech_pcie_tx_arb_pkg.sv
// Shared types and helpers for the PCIe TX-side arbiter.
//   arb_state_e : arbiter FSM state (idle between packets / transferring)
//   TLP_DW/KW   : AXI-stream TDATA / TKEEP widths of the 7-series core
//   onehot2idx  : one-hot (up to 8 bits) to binary index
package pcileech_pcie_tx_arb_pkg;

  localparam int unsigned TLP_DW = 64;
  localparam int unsigned TLP_KW = 8;

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_XFER = 1'b1
  } arb_state_e;

  // OR-reduction of set bit positions; exact for one-hot or zero input.
  function automatic logic [2:0] onehot2idx(input logic [7:0] onehot);
    logic [2:0] idx;
    idx = '0;
    for (int unsigned i = 0; i < 8; i++) begin
      if (onehot[i]) idx = idx | 3'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/pcileech_pcie_tx_arbiter_rr_picker.sv
// Combinational round-robin picker with optional strict priority for req[0].
// Ports:
//   i_req       : request vector, one bit per source
//   i_ptr       : round-robin start index (must be < NUM_SRC)
//   i_prio0_en  : 1 = req[0] beats the round-robin pool
//   o_winner_c  : index of the winning source (0 when no request)
//   o_any_req_c : at least one request present
module pcileech_rr_picker
  import pcileech_pcie_tx_arb_pkg::*;
#(
  parameter int unsigned NUM_SRC = 3,
  parameter int unsigned IDX_W   = 2
) (
  input  logic [NUM_SRC-1:0] i_req,
  input  logic [IDX_W-1:0]   i_ptr,
  input  logic               i_prio0_en,
  output logic [IDX_W-1:0]   o_winner_c,
  output logic               o_any_req_c
);

  localparam logic [IDX_W:0] NUM_SRC_W = (IDX_W+1)'(NUM_SRC);

  // Scan upward from i_ptr, wrapping modulo NUM_SRC; first hit wins.
  always_comb begin
    logic             found;
    logic [IDX_W:0]   w_sum;
    logic [IDX_W-1:0] w_idx;
    o_winner_c  = '0;
    o_any_req_c = |i_req;
    found       = 1'b0;
    w_sum       = '0;
    w_idx       = '0;
    if (i_prio0_en && i_req[0]) begin
      found = 1'b1;
    end
    for (int unsigned k = 0; k < NUM_SRC; k++) begin
      w_sum = {1'b0, i_ptr} + (IDX_W+1)'(k);
      if (w_sum >= NUM_SRC_W) w_sum = w_sum - NUM_SRC_W;
      w_idx = IDX_W'(w_sum);
      if (!found && i_req[w_idx]) begin
        found      = 1'b1;
        o_winner_c = w_idx;
      end
    end
  end

endmodule

// File: rtl/pcileech_pcie_tx_arbiter.sv
// Packet-granular arbiter sharing the PCIe core s_axis_tx port among NUM_SRC
// TLP sources. Grants only at packet boundaries, gated by core credit and
// arb_en; the data path is a zero-latency mux of the granted source.
// Ports:
//   clk_pcie, rst_n            : core user clock, async active-low reset
//   src_data/keep/last/valid   : per-source AXI-stream inputs
//   src_ready                  : per-source TREADY (only granted source)
//   tlp_tx_data/keep/last/valid, tlp_tx_ready : core s_axis_tx
//   tx_buf_av                  : core TX buffers available
//   arb_en                     : allow new grants
//   grant, busy, pkt_count     : status (one-hot grant, in XFER, packets done)
module pcileech_pcie_tx_arbiter
  import pcileech_pcie_tx_arb_pkg::*;
#(
  parameter int unsigned NUM_SRC    = 3,
  parameter int unsigned PRIO0      = 1,
  parameter int unsigned BUF_AV_MIN = 2
) (
  input  logic                      clk_pcie,
  input  logic                      rst_n,
  input  logic [NUM_SRC*TLP_DW-1:0] src_data,
  input  logic [NUM_SRC*TLP_KW-1:0] src_keep,
  input  logic [NUM_SRC-1:0]        src_last,
  input  logic [NUM_SRC-1:0]        src_valid,
  output logic [NUM_SRC-1:0]        src_ready,
  output logic [TLP_DW-1:0]         tlp_tx_data,
  output logic [TLP_KW-1:0]         tlp_tx_keep,
  output logic                      tlp_tx_last,
  output logic                      tlp_tx_valid,
  input  logic                      tlp_tx_ready,
  input  logic [5:0]                tx_buf_av,
  input  logic                      arb_en,
  output logic [NUM_SRC-1:0]        grant,
  output logic                      busy,
  output logic [31:0]               pkt_count
);

  localparam int unsigned    IDX_W        = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;
  localparam logic [5:0]     BUF_AV_MIN_W = 6'(BUF_AV_MIN);
  localparam logic [NUM_SRC-1:0] GRANT_ONE = NUM_SRC'(1);
  localparam logic [IDX_W-1:0]   LAST_IDX  = IDX_W'(NUM_SRC - 1);
  localparam logic           PRIO0_EN     = (PRIO0 != 0);

  arb_state_e         r_state;
  arb_state_e         w_state_nxt;
  logic [NUM_SRC-1:0] r_grant;
  logic [NUM_SRC-1:0] w_grant_nxt;
  logic [IDX_W-1:0]   r_rr_ptr;
  logic [IDX_W-1:0]   w_rr_ptr_nxt;
  logic [31:0]        r_pkt_count;
  logic [31:0]        w_pkt_count_nxt;
  logic [IDX_W-1:0]   w_winner;
  logic               w_any_req;
  logic [IDX_W-1:0]   w_grant_idx;
  logic               w_start;
  logic               w_eop;

  pcileech_rr_picker #(
    .NUM_SRC (NUM_SRC),
    .IDX_W   (IDX_W)
  ) u_picker (
    .i_req       (src_valid),
    .i_ptr       (r_rr_ptr),
    .i_prio0_en  (PRIO0_EN),
    .o_winner_c  (w_winner),
    .o_any_req_c (w_any_req)
  );

  assign w_grant_idx = IDX_W'(onehot2idx(8'(r_grant)));

  // Zero-latency mux of the granted source; everything low when idle.
  always_comb begin
    tlp_tx_data  = '0;
    tlp_tx_keep  = '0;
    tlp_tx_last  = 1'b0;
    tlp_tx_valid = 1'b0;
    src_ready    = '0;
    if (r_state == ST_XFER) begin
      for (int unsigned i = 0; i < NUM_SRC; i++) begin
        if (w_grant_idx == IDX_W'(i)) begin
          tlp_tx_data  = src_data[i*TLP_DW +: TLP_DW];
          tlp_tx_keep  = src_keep[i*TLP_KW +: TLP_KW];
          tlp_tx_last  = src_last[i];
          tlp_tx_valid = src_valid[i];
          src_ready[i] = tlp_tx_ready;
        end
      end
    end
  end

  assign w_start = arb_en && (tx_buf_av >= BUF_AV_MIN_W) && w_any_req;
  assign w_eop   = tlp_tx_valid && tlp_tx_ready && tlp_tx_last;

  // Next-state: arbitrate in IDLE, hold the grant until the last beat.
  always_comb begin
    w_state_nxt     = r_state;
    w_grant_nxt     = r_grant;
    w_rr_ptr_nxt    = r_rr_ptr;
    w_pkt_count_nxt = r_pkt_count;
    case (r_state)
      ST_IDLE: begin
        if (w_start) begin
          w_state_nxt = ST_XFER;
          w_grant_nxt = GRANT_ONE << w_winner;
          // A priority win by source 0 leaves the round-robin order untouched.
          if (!(PRIO0_EN && src_valid[0])) begin
            w_rr_ptr_nxt = (w_winner == LAST_IDX) ? '0 : w_winner + IDX_W'(1);
          end
        end
      end
      ST_XFER: begin
        if (w_eop) begin
          w_state_nxt     = ST_IDLE;
          w_grant_nxt     = '0;
          w_pkt_count_nxt = r_pkt_count + 32'd1;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
        w_grant_nxt = '0;
      end
    endcase
  end

  always_ff @(posedge clk_pcie or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= ST_IDLE;
      r_grant     <= '0;
      r_rr_ptr    <= '0;
      r_pkt_count <= '0;
    end else begin
      r_state     <= w_state_nxt;
      r_grant     <= w_grant_nxt;
      r_rr_ptr    <= w_rr_ptr_nxt;
      r_pkt_count <= w_pkt_count_nxt;
    end
  end

  assign grant     = r_grant;
  assign busy      = (r_state == ST_XFER);
  assign pkt_count = r_pkt_count;

endmodule

// File: doc/pcileech_pcie_tx_arbiter.md
Name: pcileech_pcie_tx_arbiter

Overview:
- Shares the single 64-bit AXI-stream TX port of the 7-series PCIe core (s_axis_tx) between NUM_SRC TLP requesters: static/cfg TLP, host FIFO TLP path, and the config-space completer.
- Arbitrates only at packet boundaries, gated by core credit (tx_buf_av) and a software enable.
- Sits in the clk_pcie (user_clk_out) domain, between the cfg/tlp subsystems and the core instance.

Parameters:
- NUM_SRC, 3, number of requesting sources (2..8).
- PRIO0, 1, 1 = source 0 has strict priority over the round-robin pool; 0 = pure round-robin.
- BUF_AV_MIN, 2, minimum tx_buf_av required to start a new packet.

Ports:
- clk_pcie  in  1  core user clock; all logic on its rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- src_data  in  NUM_SRC*64  per-source TDATA; source i occupies [64*i+63:64*i].
- src_keep  in  NUM_SRC*8  per-source TKEEP.
- src_last  in  NUM_SRC  per-source TLAST.
- src_valid  in  NUM_SRC  per-source TVALID.
- src_ready  out  NUM_SRC  per-source TREADY.
- tlp_tx_data  out  64  to core s_axis_tx_tdata.
- tlp_tx_keep  out  8  to core s_axis_tx_tkeep.
- tlp_tx_last  out  1  to core s_axis_tx_tlast.
- tlp_tx_valid  out  1  to core s_axis_tx_tvalid.
- tlp_tx_ready  in  1  from core s_axis_tx_tready.
- tx_buf_av  in  6  core TX buffers available.
- arb_en  in  1  1 = new grants allowed.
- grant  out  NUM_SRC  one-hot current grant; 0 when idle.
- busy  out  1  high while in XFER.
- pkt_count  out  32  number of completed packets; wraps.

Behaviour:
- Reset (async assert, sync-released by the clock domain): state IDLE, grant=0, rr_ptr=0, pkt_count=0, busy=0. tlp_tx_valid=0 and src_ready=0 combinationally while grant=0. tlp_tx_data/keep/last=0.
- States: IDLE, XFER.
- IDLE -> XFER when arb_en=1, tx_buf_av>=BUF_AV_MIN (unsigned compare) and |src_valid.
  - On that edge grant is registered to the winner.
  - Winner: if PRIO0 and src_valid[0], then source 0. Otherwise, the first valid source scanning upward from rr_ptr, modulo NUM_SRC.
  - rr_ptr <= (winner+1) mod NUM_SRC. A PRIO0 win of source 0 does not move rr_ptr.
- XFER: pure combinational mux, zero added latency.
  - tlp_tx_* = selected src_*.
  - src_ready[g] = tlp_tx_ready; all other src_ready = 0.
  - grant is held constant for the whole packet, regardless of arb_en, tx_buf_av or other requests.
- XFER -> IDLE on a beat with tlp_tx_valid & tlp_tx_ready & tlp_tx_last. Same edge: grant<=0, pkt_count<=pkt_count+1 (wraps 0xFFFFFFFF->0).
- One idle bubble cycle always separates packets. Re-arbitration happens in the IDLE cycle.
- Request to first beat presented: 1 cycle (grant registered).
- Single-beat packet (last on first beat): valid for exactly one accepted cycle.
- Source dropping valid mid-packet: tlp_tx_valid follows it low; the grant is held and no other source is switched in.
- arb_en deassert mid-packet: the current packet completes; no new grant afterwards.
- tx_buf_av below threshold: blocks only the start of a packet, never a packet in progress.
- Reset mid-packet: immediate return to IDLE and all outputs low. Packet truncation is accepted; the core is reset in the same event.
- Sources must follow AXI-stream rules: data stable while valid & !ready. The arbiter does not check this.

Decomposition:
- Package pcileech_pcie_tx_arb_pkg holds:
  - state enum (IDLE, XFER);
  - constants TLP_DW=64, TLP_KW=8;
  - function onehot2idx.
- Sub-module pcileech_rr_picker: purely combinational.
  - Inputs: req[NUM_SRC], ptr, prio0_en.
  - Outputs: winner index, any_req.
  - Reusable by the RX-side demux.

Test Plan:
- All three sources valid at once, PRIO0=0, single-beat packets, ready=1 -> grants 0,1,2,0 each two cycles apart; pkt_count reaches 4.
- PRIO0=1, src0 and src2 continuously requesting -> src0 granted every packet; src2 starves; rr_ptr unchanged.
- src1 sends a 4-beat packet, core ready toggles 1,0,1,0,... -> the 4 beats appear in order, each on ready=1; src0 request during the packet is deferred until after last; exactly 1 bubble cycle follows.
- tx_buf_av=1 with BUF_AV_MIN=2, src0 valid -> no grant; raise tx_buf_av to 2 -> grant on the next edge; drop it back to 0 mid-packet -> the packet still completes.
- arb_en cleared during beat 2 of a 3-beat packet -> the packet completes; src_ready stays 0 afterwards; pkt_count +1 only.
- rst_n asserted asynchronously during beat 2 -> grant, tlp_tx_valid and pkt_count go to 0 within the same cycle; after release, normal arbitration restarts from rr_ptr=0.
